// File: rtl/banner_scroller.sv
// Banner frame sequencer: walks ROM rows 0..ROWS-1 per frame, extracts a
// WIN-column scrolling window from each row and hands it out over valid/ready.
module banner_scroller #(
    parameter int unsigned ROWS       = 15,
    parameter int unsigned COLS       = 71,
    parameter int unsigned WIN        = 32,
    parameter int unsigned SCROLL_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            scroll_en,
    output logic [4:0]      rom_address,
    input  logic [COLS-1:0] rom_data,
    output logic [WIN-1:0]  row_data,
    output logic [4:0]      row_index,
    output logic            row_valid,
    input  logic            row_ready,
    output logic            frame_done,
    output logic            busy,
    output logic [6:0]      offset
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned OFF_W  = 7;
    localparam int unsigned CNT_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int unsigned DBL_W  = 2 * COLS;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        PRESENT
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [ADDR_W-1:0]  rom_address_d;
    logic [WIN-1:0]     row_data_d;
    logic [ADDR_W-1:0]  row_index_d;
    logic               row_valid_d;
    logic               frame_done_d;
    logic               busy_d;
    logic [OFF_W-1:0]   offset_d;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_cnt_d;
    logic [DBL_W-1:0]   doubled;
    logic [WIN-1:0]     window;

    // Two back-to-back copies of the row make the wrap-around a plain shift:
    // after shifting left by offset, the top WIN bits are the visible columns.
    always_comb begin
        doubled = {rom_data, rom_data} << offset;
        window  = doubled[DBL_W-1 -: WIN];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        rom_address_d = rom_address;
        row_data_d    = row_data;
        row_index_d   = row_index;
        row_valid_d   = row_valid;
        frame_done_d  = 1'b0;
        busy_d        = busy;
        offset_d      = offset;
        frame_cnt_d   = frame_cnt;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    rom_address_d = '0;
                    busy_d        = 1'b1;
                    state_d       = FETCH;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                row_data_d  = window;
                row_index_d = rom_address;
                row_valid_d = 1'b1;
                state_d     = PRESENT;
            end
            PRESENT: begin
                if (row_valid && row_ready) begin
                    row_valid_d = 1'b0;
                    if (row_index == ADDR_W'(ROWS - 1)) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                        // Scroll state only moves between frames.
                        if (scroll_en) begin
                            if (frame_cnt == CNT_W'(SCROLL_DIV - 1)) begin
                                frame_cnt_d = '0;
                                offset_d    = (offset == OFF_W'(COLS - 1)) ?
                                              '0 : offset + OFF_W'(1);
                            end else begin
                                frame_cnt_d = frame_cnt + CNT_W'(1);
                            end
                        end
                    end else begin
                        rom_address_d = row_index + ADDR_W'(1);
                        state_d       = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rom_address <= '0;
            row_data    <= '0;
            row_index   <= '0;
            row_valid   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            offset      <= '0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_d;
            rom_address <= rom_address_d;
            row_data    <= row_data_d;
            row_index   <= row_index_d;
            row_valid   <= row_valid_d;
            frame_done  <= frame_done_d;
            busy        <= busy_d;
            offset      <= offset_d;
            frame_cnt   <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_banner_scroller.sv
// Bench for banner_scroller: two instances (scroll divider 4 and 1) share the
// stimulus; a frame-level model checks every output each cycle.
`timescale 1ns/1ps
module tb_banner_scroller;

    localparam int unsigned ROWS = 15;
    localparam int unsigned COLS = 71;
    localparam int unsigned WIN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_start = 1'b0;
    logic scroll_en = 1'b0;
    logic row_ready = 1'b0;

    logic [4:0]      addr [2];
    logic [COLS-1:0] rom_q [2];
    logic [WIN-1:0]  dat [2];
    logic [4:0]      idx [2];
    logic            val [2];
    logic            done [2];
    logic            busy [2];
    logic [6:0]      off [2];

    logic [COLS-1:0] rom [ROWS];

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    banner_scroller #(.ROWS(ROWS), .COLS(COLS), .WIN(WIN), .SCROLL_DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .scroll_en(scroll_en),
        .rom_address(addr[0]), .rom_data(rom_q[0]), .row_data(dat[0]),
        .row_index(idx[0]), .row_valid(val[0]), .row_ready(row_ready),
        .frame_done(done[0]), .busy(busy[0]), .offset(off[0])
    );

    banner_scroller #(.ROWS(ROWS), .COLS(COLS), .WIN(WIN), .SCROLL_DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .scroll_en(scroll_en),
        .rom_address(addr[1]), .rom_data(rom_q[1]), .row_data(dat[1]),
        .row_index(idx[1]), .row_valid(val[1]), .row_ready(row_ready),
        .frame_done(done[1]), .busy(busy[1]), .offset(off[1])
    );

    function automatic logic [COLS-1:0] rom_word(input logic [4:0] a);
        return (int'(a) < int'(ROWS)) ? rom[a] : '0;
    endfunction

    // Registered-address ROM, one per instance.
    always @(posedge clk) begin
        rom_q[0] <= rom_word(addr[0]);
        rom_q[1] <= rom_word(addr[1]);
    end

    // Visible window: bit WIN-1-k shows banner column (o+k) mod COLS.
    function automatic logic [WIN-1:0] win_of(input logic [COLS-1:0] w, input int o);
        logic [WIN-1:0] r;
        r = '0;
        for (int k = 0; k < int'(WIN); k++) begin
            int c;
            c = (o + k) % int'(COLS);
            r[int'(WIN) - 1 - k] = w[int'(COLS) - 1 - c];
        end
        return r;
    endfunction

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: a row request becomes visible two edges after its
    // address is issued and stays until accepted.
    logic            m_active, m_valid, m_done;
    int              m_wait;
    logic [4:0]      m_addr, m_row;
    logic [WIN-1:0]  m_data [2];
    int              m_off [2];
    int              m_cnt [2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_wait <= 0;
            m_addr <= '0; m_row <= '0;
            m_data[0] <= '0; m_data[1] <= '0;
            m_off[0] <= 0; m_off[1] <= 0; m_cnt[0] <= 0; m_cnt[1] <= 0;
        end else begin : step
            logic act, vl, dn;
            int wt;
            logic [4:0] ad, rw;
            logic [WIN-1:0] dt [2];
            int of [2];
            int ct [2];
            act = m_active; vl = m_valid; wt = m_wait; ad = m_addr; rw = m_row;
            dt = m_data; of = m_off; ct = m_cnt; dn = 1'b0;
            if (!act) begin
                if (frame_start) begin act = 1'b1; ad = '0; wt = 2; end
            end else if (vl) begin
                if (row_ready) begin
                    vl = 1'b0;
                    if (int'(rw) == int'(ROWS) - 1) begin
                        act = 1'b0; dn = 1'b1;
                        if (scroll_en) begin
                            for (int i = 0; i < 2; i++) begin
                                ct[i] = ct[i] + 1;
                                if (ct[i] == div_of(i)) begin
                                    ct[i] = 0;
                                    of[i] = (of[i] + 1) % int'(COLS);
                                end
                            end
                        end
                    end else begin
                        ad = rw + 5'd1; wt = 2;
                    end
                end
            end else begin
                wt = wt - 1;
                if (wt == 0) begin
                    vl = 1'b1; rw = ad;
                    for (int i = 0; i < 2; i++) dt[i] = win_of(rom[ad], of[i]);
                end
            end
            m_active <= act; m_valid <= vl; m_done <= dn; m_wait <= wt;
            m_addr <= ad; m_row <= rw; m_data <= dt; m_off <= of; m_cnt <= ct;
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d.busy", i), 64'(busy[i]), 64'(m_active));
            check($sformatf("u%0d.row_valid", i), 64'(val[i]), 64'(m_valid));
            check($sformatf("u%0d.frame_done", i), 64'(done[i]), 64'(m_done));
            check($sformatf("u%0d.rom_address", i), 64'(addr[i]), 64'(m_addr));
            check($sformatf("u%0d.row_index", i), 64'(idx[i]), 64'(m_row));
            check($sformatf("u%0d.row_data", i), 64'(dat[i]), 64'(m_data[i]));
            check($sformatf("u%0d.offset", i), 64'(off[i]), 64'(m_off[i]));
        end
    end

    task automatic start_frame();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!val[0] && n < 50) begin @(negedge clk); n++; end
        check("row_valid seen", 64'(val[0]), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done[0] && n < budget) begin @(negedge clk); n++; end
        check("frame_done seen", 64'(done[0]), 64'd1);
    endtask

    task automatic run_frame();
        start_frame();
        wait_done(100);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nrow, nd, n;
        logic p7;
        for (int r = 0; r < int'(ROWS); r++)
            rom[r] = {32'(32'h9E3779B9 * 32'(r + 1)), 39'(64'h5DEECE66D * 64'(r + 7))};
        rom[0] = {32'hF81F81C7, 38'h15_5555_1234, 1'b1};
        rom[3] = {32'hC71C71C7, 39'h12_3456_789A};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset row_data", 64'(dat[0]), 64'd0);
        check("reset offset", 64'(off[0]), 64'd0);

        // Basic frame with the consumer always ready.
        row_ready = 1'b1;
        start_frame();
        k = 0; nrow = 0;
        while (!done[0] && k < 200) begin
            if (val[0]) begin
                check("row_index sequence", 64'(idx[0]), 64'(nrow));
                if (nrow == 0) begin
                    check("first valid latency", 64'(k), 64'd2);
                    check("row0 window u0", 64'(dat[0]), 64'hF81F81C7);
                    check("row0 window u1", 64'(dat[1]), 64'hF81F81C7);
                end
                if (nrow == 3) check("row3 window", 64'(dat[0]), 64'hC71C71C7);
                nrow++;
            end
            @(negedge clk); k++;
        end
        check("frame_done latency", 64'(k), 64'd45);
        check("rows per frame", 64'(nrow), 64'd15);
        @(negedge clk);

        // Backpressure on row 5.
        row_ready = 1'b0;
        start_frame();
        for (int r = 0; r < int'(ROWS); r++) begin
            wait_valid(n);
            if (r == 6) check("row6 after release", 64'(n + 1), 64'd3);
            if (r == 5) begin
                repeat (10) begin
                    check("stall valid", 64'(val[0]), 64'd1);
                    check("stall row_index", 64'(idx[0]), 64'd5);
                    check("stall rom_address", 64'(addr[0]), 64'd5);
                    check("stall row_data", 64'(dat[0]), 64'(win_of(rom[5], 0)));
                    @(negedge clk);
                end
            end
            row_ready = 1'b1;
            @(negedge clk);
            row_ready = 1'b0;
        end
        check("stall frame_done", 64'(done[0]), 64'd1);
        @(negedge clk);

        // Starts during row 7 and on the final handshake cycle are dropped.
        row_ready = 1'b1;
        start_frame();
        nrow = 0; nd = 0; p7 = 1'b0;
        repeat (80) begin
            frame_start = 1'b0;
            if (val[0]) nrow++;
            if (done[0]) nd++;
            if (val[0] && idx[0] == 5'd7 && !p7) begin frame_start = 1'b1; p7 = 1'b1; end
            if (val[0] && idx[0] == 5'd14) frame_start = 1'b1;
            @(negedge clk);
        end
        frame_start = 1'b0;
        check("ignored start rows", 64'(nrow), 64'd15);
        check("ignored start dones", 64'(nd), 64'd1);
        check("ignored start idle", 64'(busy[0]), 64'd0);

        // Scroll advance and freeze.
        scroll_en = 1'b1;
        repeat (8) run_frame();
        check("offset div4 after 8", 64'(off[0]), 64'd2);
        check("offset div1 after 8", 64'(off[1]), 64'd8);
        scroll_en = 1'b0;
        repeat (3) run_frame();
        check("offset frozen div4", 64'(off[0]), 64'd2);
        check("offset frozen div1", 64'(off[1]), 64'd8);

        // Asynchronous reset while row 9 is presented.
        start_frame();
        n = 0;
        while (!(val[0] && idx[0] == 5'd9) && n < 100) begin @(negedge clk); n++; end
        check("reached row 9", 64'(idx[0]), 64'd9);
        row_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("async rst rom_address", 64'(addr[i]), 64'd0);
            check("async rst row_data", 64'(dat[i]), 64'd0);
            check("async rst row_index", 64'(idx[i]), 64'd0);
            check("async rst row_valid", 64'(val[i]), 64'd0);
            check("async rst busy", 64'(busy[i]), 64'd0);
            check("async rst offset", 64'(off[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (50) begin if (done[0]) nd++; @(negedge clk); end
        check("no frame_done after reset", 64'(nd), 64'd0);
        row_ready = 1'b1;
        start_frame();
        wait_valid(n);
        check("restart row_index", 64'(idx[0]), 64'd0);
        check("restart row0 u0", 64'(dat[0]), 64'hF81F81C7);
        check("restart row0 u1", 64'(dat[1]), 64'hF81F81C7);
        wait_done(100);
        @(negedge clk);

        // Wrap-around on the divide-by-one instance.
        scroll_en = 1'b1;
        repeat (70) run_frame();
        check("offset div1 after 70", 64'(off[1]), 64'd70);
        check("offset div4 after 70", 64'(off[0]), 64'd17);
        start_frame();
        wait_valid(n);
        check("wrap row0 window", 64'(dat[1]), 64'hFC0FC0E3);
        wait_done(100);
        @(negedge clk);
        check("offset wraps to 0", 64'(off[1]), 64'd0);
        check("offset div4 after 71", 64'(off[0]), 64'd17);

        scroll_en = 1'b0;
        row_ready = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
